// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_pipe
// Description : Pipelined RISC-V immediate generator. Accepts 32-bit
//               instruction words (with PC) over valid/ready, classifies the
//               instruction format and emits an XLEN-wide immediate, format
//               code and illegal flag after STAGES register stages.
//               Optional macro IMMGEN_PCREL_EN adds out_target = pc + imm.
// Ports       : clk, rst (sync, active-high), flush (kills in-flight work)
//               in_valid/in_ready/in_inst/in_pc      : upstream handshake
//               out_valid/out_ready/out_inst/out_pc  : downstream handshake
//               out_imm, out_fmt (0=R 1=I 2=S 3=B 4=U 5=J 7=NONE),
//               out_illegal, out_target (IMMGEN_PCREL_EN only)
// Parameters  : XLEN (32|64), STAGES (1|2)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef IMMGEN_PCREL_EN
  ,
  output logic [XLEN-1:0] out_target
`endif
);

  localparam logic [2:0] c_FMT_R    = 3'd0;
  localparam logic [2:0] c_FMT_I    = 3'd1;
  localparam logic [2:0] c_FMT_S    = 3'd2;
  localparam logic [2:0] c_FMT_B    = 3'd3;
  localparam logic [2:0] c_FMT_U    = 3'd4;
  localparam logic [2:0] c_FMT_J    = 3'd5;
  localparam logic [2:0] c_FMT_NONE = 3'd7;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_MISC   = 7'b0001111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
  localparam logic [6:0] c_OP_REG32  = 7'b0111011;

  // Which bit-gathering rule the immediate assembler applies.
  typedef enum logic [2:0] {
    KIND_ZERO, KIND_I, KIND_S, KIND_B, KIND_U, KIND_J, KIND_SH, KIND_SH32
  } imm_kind_e;

  typedef struct packed {
    logic      illegal;
    logic [2:0] fmt;
    imm_kind_e kind;
  } cls_t;

  // Opcode classification. Any opcode with inst[1:0] != 2'b11 falls into
  // the default arm because every recognised opcode ends in 2'b11.
  function automatic cls_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    cls_t c;
    logic is_shift;
    is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
    c.illegal = 1'b0;
    c.fmt     = c_FMT_I;
    c.kind    = KIND_I;
    case (opcode)
      c_OP_LOAD, c_OP_MISC, c_OP_JALR, c_OP_SYSTEM: ;
      c_OP_IMM:    if (is_shift) c.kind = KIND_SH;
      c_OP_STORE:  begin c.fmt = c_FMT_S; c.kind = KIND_S; end
      c_OP_BRANCH: begin c.fmt = c_FMT_B; c.kind = KIND_B; end
      c_OP_LUI, c_OP_AUIPC: begin c.fmt = c_FMT_U; c.kind = KIND_U; end
      c_OP_JAL:    begin c.fmt = c_FMT_J; c.kind = KIND_J; end
      c_OP_REG:    begin c.fmt = c_FMT_R; c.kind = KIND_ZERO; end
      c_OP_IMM32: begin
        if (XLEN != 64) c = '{illegal: 1'b1, fmt: c_FMT_NONE, kind: KIND_ZERO};
        else if (is_shift) c.kind = KIND_SH32;
      end
      c_OP_REG32: begin
        if (XLEN != 64) c = '{illegal: 1'b1, fmt: c_FMT_NONE, kind: KIND_ZERO};
        else begin c.fmt = c_FMT_R; c.kind = KIND_ZERO; end
      end
      default: c = '{illegal: 1'b1, fmt: c_FMT_NONE, kind: KIND_ZERO};
    endcase
    return c;
  endfunction

  // Build a 32-bit sign-extended immediate, then sign-extend to XLEN.
  // Shift amounts have bit 31 clear, so the widening keeps them unsigned.
  function automatic logic [XLEN-1:0] assemble(input logic [31:7] ib, input imm_kind_e kind);
    logic [31:0] imm32;
    case (kind)
      KIND_I:    imm32 = {{20{ib[31]}}, ib[31:20]};
      KIND_S:    imm32 = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      KIND_B:    imm32 = {{20{ib[31]}}, ib[7], ib[30:25], ib[11:8], 1'b0};
      KIND_U:    imm32 = {ib[31:12], 12'b0};
      KIND_J:    imm32 = {{12{ib[31]}}, ib[19:12], ib[20], ib[30:21], 1'b0};
      KIND_SH:   imm32 = {26'b0, (XLEN == 64) ? ib[25] : 1'b0, ib[24:20]};
      KIND_SH32: imm32 = {27'b0, ib[24:20]};
      default:   imm32 = '0;
    endcase
    return XLEN'($signed(imm32));
  endfunction

  // Inputs to the final (output) register stage.
  logic            w_fin_valid;
  logic            w_fin_ready;
  logic [31:0]     w_fin_inst;
  logic [XLEN-1:0] w_fin_pc;
  cls_t            w_fin_cls;
  logic [XLEN-1:0] imm_d;

  // Final-stage state.
  logic            out_valid_q;
  logic [31:0]     out_inst_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] out_imm_q;
  logic [2:0]      out_fmt_q;
  logic            out_illegal_q;

  assign w_fin_ready = !out_valid_q || out_ready;
  assign imm_d       = assemble(w_fin_inst[31:7], w_fin_cls.kind);

  generate
    if (STAGES == 2) begin : g_two_stage
      // Stage 1 holds the raw word plus its opcode class; the immediate is
      // assembled between stage 1 and the output stage.
      logic            s1_valid_q;
      logic [31:0]     s1_inst_q;
      logic [XLEN-1:0] s1_pc_q;
      cls_t            s1_cls_q;
      logic            w_s1_ready;

      assign w_s1_ready = !s1_valid_q || w_fin_ready;
      assign in_ready   = w_s1_ready;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          s1_valid_q <= 1'b0;
        end else if (w_s1_ready) begin
          s1_valid_q <= in_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (in_valid && w_s1_ready) begin
          s1_inst_q <= in_inst;
          s1_pc_q   <= in_pc;
          s1_cls_q  <= classify(in_inst[6:0], in_inst[14:12]);
        end
      end

      assign w_fin_valid = s1_valid_q;
      assign w_fin_inst  = s1_inst_q;
      assign w_fin_pc    = s1_pc_q;
      assign w_fin_cls   = s1_cls_q;
    end else begin : g_one_stage
      assign in_ready    = w_fin_ready;
      assign w_fin_valid = in_valid;
      assign w_fin_inst  = in_inst;
      assign w_fin_pc    = in_pc;
      assign w_fin_cls   = classify(in_inst[6:0], in_inst[14:12]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid_q <= 1'b0;
    end else if (w_fin_ready) begin
      out_valid_q <= w_fin_valid;
    end
  end

  // Data only moves on a real transfer, so a stalled output holds still.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst_q    <= '0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      out_fmt_q     <= c_FMT_NONE;
      out_illegal_q <= 1'b0;
    end else if (w_fin_valid && w_fin_ready && !flush) begin
      out_inst_q    <= w_fin_inst;
      out_pc_q      <= w_fin_pc;
      out_imm_q     <= imm_d;
      out_fmt_q     <= w_fin_cls.fmt;
      out_illegal_q <= w_fin_cls.illegal;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;

`ifdef IMMGEN_PCREL_EN
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] out_target_q;

  // Wraps modulo 2^XLEN; computed for every format.
  assign target_d = w_fin_pc + imm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_target_q <= '0;
    end else if (w_fin_valid && w_fin_ready && !flush) begin
      out_target_q <= target_d;
    end
  end

  assign out_target = out_target_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_pipe
// Description : Self-checking bench for imm_decode_pipe. Two instances
//               (XLEN=32/STAGES=1 and XLEN=64/STAGES=2) are exercised in
//               turn with directed and random traffic against a reference
//               decoder and an in-order scoreboard. Honours IMMGEN_PCREL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_pipe;

  logic clk;
  logic rst;
  logic flush;

  logic        iv   [2];
  logic [31:0] ii   [2];
  logic [63:0] ip   [2];
  logic        ordy [2];

  logic        ir    [2];
  logic        ov    [2];
  logic [31:0] oinst [2];
  logic [63:0] opc   [2];
  logic [63:0] oimm  [2];
  logic [2:0]  ofmt  [2];
  logic        oill  [2];

  logic [31:0] o0_pc, o0_imm;
  logic [63:0] o1_pc, o1_imm;
  logic [31:0] o0_inst, o1_inst;

`ifdef IMMGEN_PCREL_EN
  logic [31:0] o0_tgt;
  logic [63:0] o1_tgt;
  logic [63:0] otgt [2];
  assign otgt[0] = {32'h0, o0_tgt};
  assign otgt[1] = o1_tgt;
`endif

  assign opc[0]   = {32'h0, o0_pc};
  assign oimm[0]  = {32'h0, o0_imm};
  assign opc[1]   = o1_pc;
  assign oimm[1]  = o1_imm;
  assign oinst[0] = o0_inst;
  assign oinst[1] = o1_inst;

  imm_decode_pipe #(.XLEN(32), .STAGES(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_inst(ii[0]), .in_pc(ip[0][31:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_inst(o0_inst), .out_pc(o0_pc),
    .out_imm(o0_imm), .out_fmt(ofmt[0]), .out_illegal(oill[0])
`ifdef IMMGEN_PCREL_EN
    , .out_target(o0_tgt)
`endif
  );

  imm_decode_pipe #(.XLEN(64), .STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_inst(ii[1]), .in_pc(ip[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_inst(o1_inst), .out_pc(o1_pc),
    .out_imm(o1_imm), .out_fmt(ofmt[1]), .out_illegal(oill[1])
`ifdef IMMGEN_PCREL_EN
    , .out_target(o1_tgt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   d;            // index of the instance currently under test
  logic last_acc;
  logic stalled;
  logic prev_kill;
  logic rand_ready;
  logic [31:0] snap_inst;
  logic [63:0] snap_pc, snap_imm;
  logic [2:0]  snap_fmt;
  logic        snap_ill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: dut%0d got %0h expected %0h at %0t", tag, d, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] xmask();
    return (d == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int xlen();
    return (d == 1) ? 64 : 32;
  endfunction

  function automatic int stages();
    return (d == 1) ? 2 : 1;
  endfunction

  // Keep the low n bits of x and treat bit n-1 as the sign.
  function automatic logic [63:0] sext(input logic [63:0] x, input int n);
    logic [63:0] low;
    logic [63:0] m;
    m   = (64'd1 << n) - 64'd1;
    low = x & m;
    if (((low >> (n - 1)) & 64'd1) != 0) low = low | ~m;
    return low;
  endfunction

  // Reference decoder: gathers immediate fields arithmetically from the word.
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc);
    exp_t        e;
    logic [63:0] w;
    logic [63:0] v;
    int          op;
    int          f3;
    w  = {32'h0, inst};
    op = int'(inst & 32'h7F);
    f3 = int'((inst >> 12) & 32'h7);
    v  = 0;
    e.fmt = 3'd1;
    e.ill = 1'b0;
    case (op)
      'h03, 'h0F, 'h67, 'h73: v = sext(w >> 20, 12);
      'h13: v = (f3 == 1 || f3 == 5) ? ((w >> 20) & ((xlen() == 64) ? 64'd63 : 64'd31))
                                     : sext(w >> 20, 12);
      'h23: begin e.fmt = 3'd2; v = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12); end
      'h63: begin
        e.fmt = 3'd3;
        v = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                 (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
      end
      'h37, 'h17: begin e.fmt = 3'd4; v = sext(w & 64'hFFFF_F000, 32); end
      'h6F: begin
        e.fmt = 3'd5;
        v = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                 (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
      end
      'h33: e.fmt = 3'd0;
      'h1B: begin
        if (xlen() == 64) v = (f3 == 1 || f3 == 5) ? ((w >> 20) & 31) : sext(w >> 20, 12);
        else begin e.fmt = 3'd7; e.ill = 1'b1; end
      end
      'h3B: begin
        if (xlen() == 64) e.fmt = 3'd0;
        else begin e.fmt = 3'd7; e.ill = 1'b1; end
      end
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    e.inst = inst;
    e.pc   = pc & xmask();
    e.imm  = v & xmask();
    e.tgt  = (e.pc + e.imm) & xmask();
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 14))
      0: op = 7'h03;  1: op = 7'h0F;  2: op = 7'h67;  3: op = 7'h73;
      4: op = 7'h13;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h6F; 10: op = 7'h33; 11: op = 7'h1B;
      12: op = 7'h3B; 13: op = r[6:0];
      default: op = {r[6:2], 2'b00};
    endcase
    return {r[31:7], op};
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = {$urandom, $urandom};
    return p & ~64'd3 & xmask();
  endfunction

  // One clock cycle: inputs are already set just after a falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    last_acc = iv[d] && ir[d] && !flush && !rst;
    if (prev_kill) check("valid_after_kill", ov[d], 0);
    if (stalled) begin
      check("stall_valid", ov[d], 1);
      check("stall_inst", oinst[d], snap_inst);
      check("stall_pc", opc[d], snap_pc);
      check("stall_imm", oimm[d], snap_imm);
      check("stall_fmt", ofmt[d], snap_fmt);
      check("stall_ill", oill[d], snap_ill);
    end
    if (!rst && ov[d] && ordy[d]) begin
      if (q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_inst", oinst[d], e.inst);
        check("out_pc", opc[d], e.pc);
        check("out_imm", oimm[d], e.imm);
        check("out_fmt", ofmt[d], e.fmt);
        check("out_ill", oill[d], e.ill);
`ifdef IMMGEN_PCREL_EN
        check("out_target", otgt[d], e.tgt);
`endif
      end
    end
    stalled   = !rst && !flush && ov[d] && !ordy[d];
    snap_inst = oinst[d];
    snap_pc   = opc[d];
    snap_imm  = oimm[d];
    snap_fmt  = ofmt[d];
    snap_ill  = oill[d];
    if (rst || flush) q.delete();
    else if (last_acc) q.push_back(model(ii[d], ip[d]));
    prev_kill = rst || flush;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    int n;
    ii[d] = inst;
    ip[d] = pc & xmask();
    iv[d] = 1'b1;
    n = 0;
    do begin
      if (rand_ready) ordy[d] = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end while (!last_acc && n < 64);
    if (!last_acc) check("send_timeout", 0, 1);
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    ordy[d] = 1'b1;
    iv[d]   = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("drain_empty", q.size(), 0);
    cycle();
    check("drain_idle", ov[d], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    ordy[d] = 1'b1;
    cycle();
    cycle();
    check("rst_valid", ov[d], 0);
    check("rst_fmt", ofmt[d], 7);
    check("rst_imm", oimm[d], 0);
    check("rst_pc", opc[d], 0);
    check("rst_inst", oinst[d], 0);
    check("rst_ill", oill[d], 0);
`ifdef IMMGEN_PCREL_EN
    check("rst_target", otgt[d], 0);
`endif
    rst = 1'b0;
    check("rst_ready", ir[d], 1);
  endtask

  // Single instruction through an idle pipe: latency plus fixed expectations.
  task automatic directed(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                          input logic [63:0] eimm, input logic [2:0] efmt, input logic eill,
                          input logic [63:0] etgt);
    int lat;
    ordy[d] = 1'b1;
    ii[d] = inst;
    ip[d] = pc & xmask();
    iv[d] = 1'b1;
    cycle();
    check({tag, "_accept"}, last_acc, 1);
    iv[d] = 1'b0;
    lat = 1;
    while (!ov[d] && lat < 8) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, stages());
    check({tag, "_imm"}, oimm[d], eimm & xmask());
    check({tag, "_fmt"}, ofmt[d], efmt);
    check({tag, "_ill"}, oill[d], eill);
`ifdef IMMGEN_PCREL_EN
    check({tag, "_target"}, otgt[d], etgt & xmask());
`else
    if (etgt == 64'h0) check({tag, "_no_target_pc"}, opc[d], pc & xmask());
`endif
    cycle();
  endtask

  task automatic stall_test();
    logic [31:0] ins [4];
    int k;
    for (int i = 0; i < 4; i++) ins[i] = rand_inst();
    ordy[d] = 1'b0;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      ii[d] = ins[k];
      ip[d] = (64'h1000 + 64'(k * 4)) & xmask();
      iv[d] = 1'b1;
      cycle();
      if (last_acc) k++;
    end
    check("stall_accepted", k, stages());
    check("stall_in_ready", ir[d], 0);
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    while (k < 4) begin
      send(ins[k], 64'h1000 + 64'(k * 4));
      k++;
    end
    drain();
  endtask

  task automatic flush_test();
    ordy[d] = 1'b0;
    for (int i = 0; i < stages(); i++) send(rand_inst(), rand_pc());
    ii[d] = rand_inst();
    ip[d] = rand_pc();
    iv[d] = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    iv[d] = 1'b0;
    check("flush_valid", ov[d], 0);
    ordy[d] = 1'b1;
    repeat (4) cycle();
    send(32'h00500093, 64'h2000);
    drain();
  endtask

  task automatic rst_mid_test();
    ordy[d] = 1'b0;
    for (int i = 0; i < stages(); i++) send(rand_inst(), rand_pc());
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rstmid_valid", ov[d], 0);
    check("rstmid_fmt", ofmt[d], 7);
    check("rstmid_ready", ir[d], 1);
    ordy[d] = 1'b1;
    repeat (3) cycle();
    drain();
  endtask

  task automatic random_test(input int n);
    rand_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        iv[d] = 1'b0;
        ordy[d] = ($urandom_range(0, 3) != 0);
        cycle();
      end
      send(rand_inst(), rand_pc());
    end
    rand_ready = 1'b0;
    drain();
  endtask

  task automatic run_suite();
    stalled = 1'b0;
    prev_kill = 1'b0;
    q.delete();
    do_reset();
    directed("addi", 32'hFFF00093, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 64'h3F);
    directed("beq", 32'hFE000EE3, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 64'hFC);
    directed("srai", 32'h4030D093, 64'h200, 64'h3, 3'd1, 1'b0, 64'h203);
    directed("lui", 32'h800000B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0,
             64'hFFFF_FFFF_8000_0000);
    directed("slli32", 32'h02009093, 64'h8, (d == 1) ? 64'd32 : 64'd0, 3'd1, 1'b0,
             (d == 1) ? 64'h28 : 64'h8);
    if (d == 1) directed("addiw", 32'h0000001B, 64'h300, 64'h0, 3'd1, 1'b0, 64'h300);
    else        directed("addiw", 32'h0000001B, 64'h300, 64'h0, 3'd7, 1'b1, 64'h300);
    directed("custom0", 32'h0000000B, 64'h10, 64'h0, 3'd7, 1'b1, 64'h10);
    directed("len16", 32'h00000010, 64'h20, 64'h0, 3'd7, 1'b1, 64'h20);
    stall_test();
    flush_test();
    random_test(300);
    rst_mid_test();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    rand_ready = 1'b0;
    last_acc = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      ii[k] = '0;
      ip[k] = '0;
      ordy[k] = 1'b1;
    end
    d = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      d = k;
      run_suite();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
- Parametrised, pipelined successor to the core's combinational immediate generator.
- Accepts 32-bit instruction words (with PC) over a valid/ready handshake and classifies the format.
- Produces an XLEN-wide sign/zero-extended immediate, format code and illegal flag after STAGES register stages.
- Sits between fetch and register-read; supports RV32I/RV64I base opcodes, shift-amount extraction and pipeline flush.

Parameters:
- XLEN, 32, datapath width of imm/pc. Legal values: 32 or 64.
- STAGES, 1, number of register stages. Legal values: 1 or 2. With 2: stage 1 registers opcode class; stage 2 registers the assembled immediate.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous kill of all in-flight entries
- in_valid  input  1  instruction presented
- in_ready  output  1  block can accept this cycle
- in_inst  input  32  instruction word
- in_pc  input  XLEN  instruction address
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_inst  output  32  instruction carried through
- out_pc  output  XLEN  pc carried through
- out_imm  output  XLEN  immediate
- out_fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=NONE
- out_illegal  output  1  unrecognised opcode / bad length
- out_target  output  XLEN  pc+imm, present only with IMMGEN_PCREL_EN

Behaviour:
- Reset (rst=1 at clk edge): all stage valids=0; out_valid=0; out_imm/out_pc/out_inst/out_target=0; out_fmt=7; out_illegal=0.
- Handshake:
  - Transfer occurs when valid&&ready at the clock edge.
  - Each stage loads when its input valid && (!stage_valid || downstream ready).
  - in_ready = !stage1_valid || stage1 advancing (combinational ready chain).
  - Full throughput: 1 instr/cycle.
  - While out_valid && !out_ready, every output holds stable.
- Latency: an accepted instruction appears at the outputs exactly STAGES cycles later if unblocked. Order is preserved; no drops or duplicates.
- Decode (by inst[6:0]):
  - inst[1:0] != 2'b11 -> fmt NONE, illegal=1, imm=0.
  - 0000011 LOAD, 0001111 MISC-MEM, 1100111 JALR, 1110011 SYSTEM -> I.
  - 0010011 OP-IMM -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> R, imm=0.
  - 0011011 OP-IMM-32 -> I and 0111011 OP-32 -> R, legal only when XLEN=64. When XLEN=32 -> NONE, illegal=1.
  - Any other opcode -> NONE, illegal=1, imm=0.
- Immediate assembly, sign-extended from inst[31] to XLEN:
  - I = inst[31:20]
  - S = {inst[31:25],inst[11:7]}
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U = {inst[31:12],12'b0}, sign-extended above bit 31 when XLEN=64
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],0}
- Shifts: OP-IMM with funct3=001/101 -> imm = zero-extended shamt. Shamt is inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64). OP-IMM-32 shifts always use inst[24:20]. funct7 travels only in out_inst.
- Flush:
  - All stage valids clear at the edge; out_valid=0 the next cycle.
  - Any in_valid&&in_ready handshake in the flush cycle is discarded.
  - Data registers need not clear.
- rst overrides flush. rst mid-stream discards all in-flight entries; in_ready=1 the cycle after reset deasserts.

Optional Feature:
- Macro: IMMGEN_PCREL_EN.
- Defined:
  - Adds port out_target = out_pc + out_imm, XLEN-bit modulo-2^XLEN add.
  - Computed in the final stage and registered with the rest; latency unchanged.
  - Value is meaningful for B, J and AUIPC, and computed regardless of format.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), XLEN=32, STAGES=1, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0.
- 0xFE000EE3 (beq -4), STAGES=2 -> two cycles later imm=0xFFFFFFFC, fmt=3. With IMMGEN_PCREL_EN and pc=0x100 -> target=0xFC.
- 0x4030D093 (srai x1,x1,3) -> imm=0x3, fmt=1. XLEN=64, 0x0000001B -> legal fmt=1. Same word at XLEN=32 -> illegal=1, fmt=7, imm=0.
- STAGES=2, back-to-back 4 instructions with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; all 4 emerge in order, no loss or duplication, outputs stable while stalled.
- flush asserted while 2 entries in flight and in_valid=1 -> out_valid=0 next cycle; none of the 3 instructions ever emerges; next accepted instruction emerges normally.
- 0x0000000B and 0x00000013 with inst[1:0]=00 (0x00000010) -> illegal=1, fmt=7, imm=0. Assert rst mid-stream -> out_valid=0, fmt=7 the following cycle.
